// File: rtl/lf_window_sequencer.sv
// lf_window_sequencer: circular multi-channel sample store with sliding-window replay.
// Build option: define LFWS_PENDING_EN for a one-deep pending trigger slot.
module lf_window_sequencer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int WINDOW = 1021,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrt_smpl,
  input  logic [NUM_CH*WIDTH-1:0] smpl_in,
  output logic [NUM_CH*WIDTH-1:0] smpl_out,
  output logic                    sequencing,
  output logic                    full,
  output logic                    ovr
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(WINDOW + 1);

  localparam logic [AW-1:0] START_OFS = AW'((DEPTH + 1 - WINDOW) % DEPTH);
  localparam logic [FW-1:0] WIN_F     = FW'(WINDOW);
  localparam logic [FW-1:0] WIN_M1    = FW'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_READ
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [FW-1:0] r_fill;
  logic [FW-1:0] r_beat;
  logic          r_full;
  logic          r_seq;
  logic          r_ovr;

  logic          w_trig;
  logic          w_busy;
  logic          w_last;
  logic          w_rd_en;
  logic [AW-1:0] w_start;
  logic [FW-1:0] w_fill_nxt;
  logic          w_lost;
  logic          w_next_v;
  logic [AW-1:0] w_next_addr;

  assign w_trig     = wrt_smpl && (r_fill >= WIN_M1);
  assign w_busy     = (r_state != S_IDLE);
  assign w_last     = (r_state == S_READ) && (r_beat == WIN_M1);
  assign w_rd_en    = (r_state == S_PRIME) || (r_state == S_READ);
  assign w_start    = r_wr_ptr + START_OFS;
  assign w_fill_nxt = (r_fill == WIN_F) ? r_fill : r_fill + FW'(1);

`ifdef LFWS_PENDING_EN
  logic          r_pend_v;
  logic [AW-1:0] r_pend_addr;
  logic          w_store;

  // A trigger landing on the final beat with an empty slot chains directly.
  assign w_store     = w_trig && w_busy && !r_pend_v && !w_last;
  assign w_lost      = w_trig && w_busy && r_pend_v;
  assign w_next_v    = r_pend_v || w_trig;
  assign w_next_addr = r_pend_v ? r_pend_addr : w_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
    end else if (w_store) begin
      r_pend_v    <= 1'b1;
      r_pend_addr <= w_start;
    end else if (w_last) begin
      r_pend_v    <= 1'b0;
    end
  end
`else
  assign w_lost      = w_trig && w_busy;
  assign w_next_v    = 1'b0;
  assign w_next_addr = w_start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
    end else if (wrt_smpl) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      r_fill   <= w_fill_nxt;
      r_full   <= (w_fill_nxt == WIN_F);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rd_ptr <= '0;
      r_beat   <= '0;
      r_seq    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_lost)
        r_ovr <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_rd_ptr <= w_start;
            r_beat   <= '0;
            r_state  <= S_PRIME;
          end
        end
        S_PRIME: begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_seq    <= 1'b1;
          r_state  <= S_READ;
        end
        S_READ: begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_beat   <= r_beat + FW'(1);
          if (w_last) begin
            r_seq  <= 1'b0;
            r_beat <= '0;
            if (w_next_v) begin
              r_rd_ptr <= w_next_addr;
              r_state  <= S_PRIME;
            end else begin
              r_state  <= S_IDLE;
            end
          end
        end
        default: begin
          r_seq   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
      if (wrt_smpl && !rst)
        r_mem[r_wr_ptr] <= smpl_in[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
      if (rst)
        r_q <= '0;
      else if (w_rd_en)
        r_q <= r_mem[r_rd_ptr];
    end

    assign smpl_out[k*WIDTH +: WIDTH] = r_q;
  end

  assign sequencing = r_seq;
  assign full       = r_full;
  assign ovr        = r_ovr;

endmodule

// File: tb/tb_lf_window_sequencer.sv
// tb_lf_window_sequencer: directed checks of fill, replay, wrap, chaining and reset.
// Expectations follow LFWS_PENDING_EN when it is defined for the build.
module tb_lf_window_sequencer;

  localparam int W    = 16;
  localparam int D    = 16;
  localparam int WIN  = 13;
  localparam int NC   = 2;
  localparam int NOBS = 64;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          wrt_smpl = 1'b0;
  logic [NC*W-1:0] smpl_in = '0;
  logic [NC*W-1:0] smpl_out;
  logic          sequencing;
  logic          full;
  logic          ovr;

  lf_window_sequencer #(
    .WIDTH (W),
    .DEPTH (D),
    .WINDOW(WIN),
    .NUM_CH(NC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wrt_smpl  (wrt_smpl),
    .smpl_in   (smpl_in),
    .smpl_out  (smpl_out),
    .sequencing(sequencing),
    .full      (full),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        exp_full;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[45];

  int errs   = 0;
  int checks = 0;

  logic [15:0] hist[$];
  int          nobs;
  logic        o_seq [NOBS];
  logic [31:0] o_out [NOBS];
  logic        o_full[NOBS];
  logic        o_ovr [NOBS];
  logic        e_seq [NOBS];
  logic [15:0] e_val [NOBS];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_obs();
    nobs = 0;
    for (int i = 0; i < NOBS; i++) begin
      e_seq[i] = 1'b0;
      e_val[i] = '0;
    end
  endtask

  task automatic tick(input logic r, input logic w, input logic [15:0] v);
    rst      = r;
    wrt_smpl = w;
    smpl_in  = {~v, v};
    @(posedge clk);
    #1;
    if (w && !r) hist.push_back(v);
    if (nobs < NOBS) begin
      o_seq[nobs]  = sequencing;
      o_out[nobs]  = smpl_out;
      o_full[nobs] = full;
      o_ovr[nobs]  = ovr;
      nobs++;
    end
    wrt_smpl = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic expect_pass(input int start, input int last);
    for (int i = 0; i < WIN; i++) begin
      e_seq[start+i] = 1'b1;
      e_val[start+i] = hist[last-WIN+1+i];
    end
  endtask

  task automatic check_window(input string nm);
    logic [15:0] inv;
    for (int k = 0; k < nobs; k++) begin
      chk($sformatf("%s seq[%0d]", nm, k), 32'(o_seq[k]), 32'(e_seq[k]));
      if (e_seq[k]) begin
        inv = ~e_val[k];
        chk($sformatf("%s ch0[%0d]", nm, k), 32'(o_out[k][15:0]),
            32'(e_val[k]));
        chk($sformatf("%s ch1[%0d]", nm, k), 32'(o_out[k][31:16]),
            32'(inv));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p1;
    int p2;
    for (int n = 1; n <= 45; n++)
      vecs[n-1] = '{16'(n), (n >= WIN), (n >= WIN)};

    clear_obs();
    tick(1'b1, 1'b1, 16'h5555);
    tick(1'b1, 1'b1, 16'h5555);
    chk("rst seq",  32'(sequencing), 32'd0);
    chk("rst full", 32'(full), 32'd0);
    chk("rst ovr",  32'(ovr), 32'd0);
    chk("rst out",  smpl_out, 32'd0);
    hist.delete();

    for (int n = 0; n < 45; n++) begin
      clear_obs();
      tick(1'b0, 1'b1, vecs[n].val);
      if (vecs[n].exp_pass) expect_pass(1, hist.size() - 1);
      repeat (19) tick(1'b0, 1'b0, 16'h0);
      chk($sformatf("w%0d full", n + 1), 32'(o_full[0]),
          32'(vecs[n].exp_full));
      chk($sformatf("w%0d ovr", n + 1), 32'(o_ovr[nobs-1]), 32'd0);
      check_window($sformatf("w%0d", n + 1));
    end

    clear_obs();
    tick(1'b0, 1'b1, 16'd100);
    p1 = hist.size() - 1;
    expect_pass(1, p1);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'd101);
    p2 = hist.size() - 1;
`ifdef LFWS_PENDING_EN
    expect_pass(15, p2);
`endif
    repeat (36) tick(1'b0, 1'b0, 16'h0);
    check_window("b2b");
`ifdef LFWS_PENDING_EN
    chk("b2b ovr", 32'(o_ovr[nobs-1]), 32'd0);

    clear_obs();
    tick(1'b0, 1'b1, 16'd110);
    p1 = hist.size() - 1;
    expect_pass(1, p1);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'd111);
    p2 = hist.size() - 1;
    expect_pass(15, p2);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'd112);
    repeat (34) tick(1'b0, 1'b0, 16'h0);
    check_window("tri");
    chk("tri ovr pre",  32'(o_ovr[4]), 32'd0);
    chk("tri ovr post", 32'(o_ovr[5]), 32'd1);
    chk("tri ovr end",  32'(o_ovr[nobs-1]), 32'd1);
`else
    chk("b2b ovr pre", 32'(o_ovr[2]), 32'd0);
    chk("b2b ovr",     32'(o_ovr[nobs-1]), 32'd1);
`endif

    clear_obs();
    tick(1'b0, 1'b1, 16'd200);
    expect_pass(1, hist.size() - 1);
    repeat (5) tick(1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    hist.delete();
    for (int k = 6; k < NOBS; k++) e_seq[k] = 1'b0;
    repeat (10) tick(1'b0, 1'b0, 16'h0);
    check_window("rstmid");
    chk("rstmid full", 32'(o_full[6]), 32'd0);
    chk("rstmid ovr",  32'(o_ovr[6]), 32'd0);
    chk("rstmid out",  o_out[6], 32'd0);

    for (int n = 1; n <= WIN; n++) begin
      clear_obs();
      tick(1'b0, 1'b1, 16'(300 + n));
      if (n == WIN) expect_pass(1, hist.size() - 1);
      repeat (19) tick(1'b0, 1'b0, 16'h0);
      chk($sformatf("r%0d full", n), 32'(o_full[0]), 32'(n == WIN));
      check_window($sformatf("r%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
